stdp_update_engine: RTL and testbench

Sequential, parametrised STDP weight-update engine for one post-synaptic neuron. On a post-spike `start`, it sweeps all `N_SYN` synapses: it reads each synapse's last pre-spike time and current weight from synapse memory, applies the windowed STDP rule with saturation, and writes back only the weights that change. It sits between the post-neuron spike logic and the synapse weight RAM. It replaces the per-synapse combinational updater with a single shared datapath, a memory handshake and a test-mode bypass.

---
 rtl/stdp_pkg.sv | 36 +++
 rtl/stdp_weight_calc.sv | 51 +++++
 rtl/stdp_update_engine.sv | 132 +++++++++++++
 tb/tb_stdp_update_engine.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/stdp_pkg.sv
// +----------------------------------------------------------------------------+
// | stdp_pkg: shared constants, FSM state type and the STDP delta function.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package stdp_pkg;

  localparam int DEF_W_MAX = 3;
  localparam int DEF_WIN1  = 1;
  localparam int DEF_WIN2  = 2;
  localparam int DEF_A1    = 2;
  localparam int DEF_A2    = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_FIN  = 2'd3
  } stdp_state_e;

  // Positive dt (post after pre) potentiates, negative dt depresses.
  function automatic int stdp_delta(input int dt, input int win1, input int win2,
                                    input int a1, input int a2);
    int d;
    d = 0;
    if (dt > 0 && dt <= win1)               d = a1;
    else if (dt > win1 && dt <= win2)       d = a2;
    else if (dt < 0 && dt >= -win1)         d = -a1;
    else if (dt < -win1 && dt >= -win2)     d = -a2;
    return d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/stdp_weight_calc.sv
// +----------------------------------------------------------------------------+
// | stdp_weight_calc: combinational dt, delta, clamp and change detection.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module stdp_weight_calc
  import stdp_pkg::*;
#(
  parameter int W_WIDTH = 4,
  parameter int T_WIDTH = 7,
  parameter int W_MAX   = DEF_W_MAX,
  parameter int WIN1    = DEF_WIN1,
  parameter int WIN2    = DEF_WIN2,
  parameter int A1      = DEF_A1,
  parameter int A2      = DEF_A2
) (
  input  logic [T_WIDTH-1:0] time_post_i,
  input  logic [T_WIDTH-1:0] rd_time_i,
  input  logic               rd_valid_i,
  input  logic [W_WIDTH-1:0] rd_weight_i,
  output logic [W_WIDTH-1:0] new_weight_o,
  output logic               changed_o
);

  localparam int SW = W_WIDTH + 2;
  localparam logic signed [SW-1:0] C_WMAX = SW'(W_MAX);

  logic signed [T_WIDTH:0] w_dt;
  logic signed [SW-1:0]    w_delta;
  logic signed [SW-1:0]    w_sum;

  // Plain signed difference; timestamps are assumed not to wrap within a window.
  assign w_dt    = $signed({1'b0, time_post_i}) - $signed({1'b0, rd_time_i});
  assign w_delta = rd_valid_i ? SW'(stdp_delta(int'(w_dt), WIN1, WIN2, A1, A2)) : '0;
  assign w_sum   = $signed({2'b00, rd_weight_i}) + w_delta;

  always_comb begin
    new_weight_o = w_sum[W_WIDTH-1:0];
    if (w_sum[SW-1]) begin
      new_weight_o = '0;
    end else if (w_sum > C_WMAX) begin
      new_weight_o = W_WIDTH'(W_MAX);
    end
  end

  assign changed_o = (new_weight_o != rd_weight_i);

endmodule

`default_nettype wire

// File: rtl/stdp_update_engine.sv
// +----------------------------------------------------------------------------+
// | stdp_update_engine: sequential STDP sweep over all synapses of one neuron,|
// | read/modify/write against synapse memory. Revision: 1.0                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module stdp_update_engine
  import stdp_pkg::*;
#(
  parameter int W_WIDTH = 4,
  parameter int T_WIDTH = 7,
  parameter int N_SYN   = 16,
  parameter int W_MAX   = DEF_W_MAX,
  parameter int WIN1    = DEF_WIN1,
  parameter int WIN2    = DEF_WIN2,
  parameter int A1      = DEF_A1,
  parameter int A2      = DEF_A2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [T_WIDTH-1:0]           time_post,
  input  logic                         testing,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(N_SYN+1)-1:0]   upd_count,
  output logic                         rd_en,
  output logic [$clog2(N_SYN)-1:0]     rd_addr,
  input  logic [T_WIDTH-1:0]           rd_time,
  input  logic                         rd_valid,
  input  logic [W_WIDTH-1:0]           rd_weight,
  output logic                         wr_en,
  output logic [$clog2(N_SYN)-1:0]     wr_addr,
  output logic [W_WIDTH-1:0]           wr_data
);

  localparam int IDX_W = $clog2(N_SYN);
  localparam int CNT_W = $clog2(N_SYN + 1);
  localparam logic [IDX_W-1:0] C_LAST = IDX_W'(N_SYN - 1);

  stdp_state_e        state_q, state_d;
  logic [IDX_W-1:0]   idx_q;
  logic [T_WIDTH-1:0] tp_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               wr_en_q;
  logic [IDX_W-1:0]   wr_addr_q;
  logic [W_WIDTH-1:0] wr_data_q;

  logic               w_accept;
  logic               w_last;
  logic [W_WIDTH-1:0] w_new_weight;
  logic               w_changed;

  assign w_accept = (state_q == ST_IDLE) && start;
  assign w_last   = (idx_q == C_LAST);

  stdp_weight_calc #(
    .W_WIDTH (W_WIDTH),
    .T_WIDTH (T_WIDTH),
    .W_MAX   (W_MAX),
    .WIN1    (WIN1),
    .WIN2    (WIN2),
    .A1      (A1),
    .A2      (A2)
  ) u_calc (
    .time_post_i  (tp_q),
    .rd_time_i    (rd_time),
    .rd_valid_i   (rd_valid),
    .rd_weight_i  (rd_weight),
    .new_weight_o (w_new_weight),
    .changed_o    (w_changed)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = testing ? ST_FIN : ST_RD;
      ST_RD:   state_d = ST_WR;
      ST_WR:   state_d = w_last ? ST_FIN : ST_RD;
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Write for synapse i is registered here, so it overlaps the read of i+1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q     <= '0;
      tp_q      <= '0;
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= 1'b0;
      if (w_accept) begin
        tp_q  <= time_post;
        idx_q <= '0;
        cnt_q <= '0;
      end
      if (state_q == ST_WR) begin
        wr_en_q   <= w_changed;
        wr_addr_q <= idx_q;
        wr_data_q <= w_new_weight;
        if (w_changed) cnt_q <= cnt_q + CNT_W'(1);
        if (!w_last)   idx_q <= idx_q + IDX_W'(1);
      end
    end
  end

  always_comb begin
    busy      = (state_q == ST_RD) || (state_q == ST_WR);
    done      = (state_q == ST_FIN);
    rd_en     = (state_q == ST_RD);
    rd_addr   = idx_q;
    wr_en     = wr_en_q;
    wr_addr   = wr_addr_q;
    wr_data   = wr_data_q;
    upd_count = cnt_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_stdp_update_engine.sv
// +----------------------------------------------------------------------------+
// | tb_stdp_update_engine: table vectors, randomized sweeps against an integer|
// | STDP model, and hand-written reset/testing-mode sequences. Revision: 1.0  |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_stdp_update_engine;

  localparam int N = 16;

  logic       clk, reset, start, testing;
  logic [6:0] time_post;
  logic       busy, done, rd_en, wr_en;
  logic [4:0] upd_count;
  logic [3:0] rd_addr, wr_addr;
  logic [6:0] rd_time;
  logic       rd_valid;
  logic [3:0] rd_weight, wr_data;

  stdp_update_engine dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .time_post (time_post),
    .testing   (testing),
    .busy      (busy),
    .done      (done),
    .upd_count (upd_count),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_time   (rd_time),
    .rd_valid  (rd_valid),
    .rd_weight (rd_weight),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] mem_t [N];
  bit         mem_v [N];
  logic [3:0] mem_w [N];

  // Synchronous-read synapse memory: data valid the cycle after rd_en.
  always @(posedge clk) begin
    if (rd_en) begin
      rd_time   <= mem_t[rd_addr];
      rd_valid  <= mem_v[rd_addr];
      rd_weight <= mem_w[rd_addr];
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  bit exp_wr_a [N];
  int exp_wd_a [N];
  int exp_cnt;

  typedef struct {
    int rt;
    bit v;
    int w;
    int exp_w;
    bit exp_wr;
  } vec_t;
  vec_t tbl [N];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference STDP rule on plain integers.
  function automatic int ref_weight(input int tp, input int t, input bit v, input int w);
    int dt, d, nw;
    dt = tp - t;
    d  = 0;
    if (v) begin
      if (dt >= 1 && dt <= 1)        d = 2;
      else if (dt == 2)              d = 1;
      else if (dt == -1)             d = -2;
      else if (dt == -2)             d = -1;
    end
    nw = w + d;
    if (nw < 0) nw = 0;
    if (nw > 3) nw = 3;
    return nw;
  endfunction

  task automatic model_expect(input int tp);
    int nw;
    exp_cnt = 0;
    for (int i = 0; i < N; i++) begin
      nw = ref_weight(tp, int'(mem_t[i]), mem_v[i], int'(mem_w[i]));
      exp_wr_a[i] = (nw != int'(mem_w[i]));
      exp_wd_a[i] = nw;
      if (exp_wr_a[i]) exp_cnt++;
    end
  endtask

  // Issue start, then check every cycle of the sweep; glitch_e pulses start again.
  task automatic run_sweep(input int tp, input bit tst, input int glitch_e);
    int  last;
    bit  e_busy, e_done, e_rd, e_wr;
    int  wi;
    last = tst ? 1 : 2 * N + 1;
    @(negedge clk);
    time_post = 7'(tp);
    testing   = tst;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int e = 1; e <= last + 1; e++) begin
      if (tst) begin
        e_busy = 0; e_done = (e == 1); e_rd = 0; e_wr = 0; wi = 0;
      end else begin
        e_busy = (e <= 2 * N);
        e_done = (e == 2 * N + 1);
        e_rd   = (e % 2 == 1) && (e <= 2 * N - 1);
        wi     = (e - 3) / 2;
        e_wr   = (e % 2 == 1) && (e >= 3) && (e <= 2 * N + 1) && exp_wr_a[wi];
      end
      check($sformatf("busy@e%0d", e), int'(busy), int'(e_busy));
      check($sformatf("done@e%0d", e), int'(done), int'(e_done));
      check($sformatf("rd_en@e%0d", e), int'(rd_en), int'(e_rd));
      check($sformatf("wr_en@e%0d", e), int'(wr_en), int'(e_wr));
      if (e_rd) check($sformatf("rd_addr@e%0d", e), int'(rd_addr), (e - 1) / 2);
      if (e_wr && wr_en) begin
        check($sformatf("wr_addr@e%0d", e), int'(wr_addr), wi);
        check($sformatf("wr_data@e%0d", e), int'(wr_data), exp_wd_a[wi]);
      end
      if (e >= last) check($sformatf("upd_count@e%0d", e), int'(upd_count), exp_cnt);
      if (wr_en) mem_w[wr_addr] = wr_data;
      start     = (e == glitch_e);
      testing   = 1'($urandom);
      time_post = 7'($urandom);
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  task automatic rand_sweep(input int glitch_e);
    int tp;
    tp = int'($urandom_range(10, 117));
    for (int i = 0; i < N; i++) begin
      mem_t[i] = 7'(tp + int'($urandom_range(0, 8)) - 4);
      mem_v[i] = ($urandom_range(0, 3) != 0);
      mem_w[i] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15))
                                             : 4'($urandom_range(0, 3));
    end
    model_expect(tp);
    run_sweep(tp, 1'b0, glitch_e);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; testing = 1'b0; time_post = '0;
    tbl[0]  = '{9,   1, 1, 3, 1};
    tbl[1]  = '{12,  1, 1, 0, 1};
    tbl[2]  = '{8,   1, 3, 3, 0};
    tbl[3]  = '{10,  1, 2, 2, 0};
    tbl[4]  = '{7,   1, 1, 1, 0};
    tbl[5]  = '{13,  1, 1, 1, 0};
    tbl[6]  = '{9,   1, 0, 2, 1};
    tbl[7]  = '{11,  1, 3, 1, 1};
    tbl[8]  = '{8,   1, 0, 1, 1};
    tbl[9]  = '{12,  1, 2, 1, 1};
    tbl[10] = '{9,   0, 1, 1, 0};
    tbl[11] = '{11,  1, 0, 0, 0};
    tbl[12] = '{100, 1, 2, 2, 0};
    tbl[13] = '{0,   1, 3, 3, 0};
    tbl[14] = '{11,  1, 1, 0, 1};
    tbl[15] = '{9,   1, 2, 3, 1};

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_rd_en", int'(rd_en), 0);
    check("rst_wr_en", int'(wr_en), 0);
    check("rst_rd_addr", int'(rd_addr), 0);
    check("rst_wr_addr", int'(wr_addr), 0);
    check("rst_wr_data", int'(wr_data), 0);
    check("rst_upd_count", int'(upd_count), 0);
    @(negedge clk);
    reset = 1'b1;

    // Hand-derived vectors, time_post = 10, with a start pulse while busy.
    exp_cnt = 0;
    for (int i = 0; i < N; i++) begin
      mem_t[i] = 7'(tbl[i].rt);
      mem_v[i] = tbl[i].v;
      mem_w[i] = 4'(tbl[i].w);
      exp_wr_a[i] = tbl[i].exp_wr;
      exp_wd_a[i] = tbl[i].exp_w;
      if (tbl[i].exp_wr) exp_cnt++;
    end
    run_sweep(10, 1'b0, 9);
    for (int i = 0; i < N; i++)
      check($sformatf("tbl_weight[%0d]", i), int'(mem_w[i]), tbl[i].exp_w);

    // Testing mode after a sweep that changed weights.
    exp_cnt = 0;
    for (int i = 0; i < N; i++) exp_wr_a[i] = 0;
    run_sweep(40, 1'b1, 0);

    // No recorded pre-spikes: nothing may be written.
    for (int i = 0; i < N; i++) begin
      mem_t[i] = 7'(50 + int'($urandom_range(0, 4)) - 2);
      mem_v[i] = 1'b0;
      mem_w[i] = 4'($urandom_range(0, 3));
      exp_wr_a[i] = 0;
    end
    exp_cnt = 0;
    run_sweep(50, 1'b0, 0);

    rand_sweep(0);
    rand_sweep(7);
    rand_sweep(2 * N + 1);
    rand_sweep(0);
    rand_sweep(20);
    rand_sweep(0);

    // Reset during the read of synapse 5.
    for (int i = 0; i < N; i++) begin
      mem_t[i] = 7'(50 + int'($urandom_range(0, 4)) - 2);
      mem_v[i] = 1'b1;
      mem_w[i] = 4'($urandom_range(0, 3));
    end
    @(negedge clk);
    time_post = 7'd50; testing = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("mid_rd_en", int'(rd_en), 1);
    check("mid_rd_addr", int'(rd_addr), 5);
    #2;
    reset = 1'b0;
    #1;
    check("async_busy", int'(busy), 0);
    check("async_done", int'(done), 0);
    check("async_rd_en", int'(rd_en), 0);
    check("async_rd_addr", int'(rd_addr), 0);
    check("async_wr_en", int'(wr_en), 0);
    check("async_wr_addr", int'(wr_addr), 0);
    check("async_wr_data", int'(wr_data), 0);
    check("async_upd_count", int'(upd_count), 0);
    repeat (2) begin
      @(posedge clk); #1;
      check("inrst_wr_en", int'(wr_en), 0);
      check("inrst_busy", int'(busy), 0);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      check("post_rst_busy", int'(busy), 0);
      check("post_rst_rd_en", int'(rd_en), 0);
      check("post_rst_wr_en", int'(wr_en), 0);
    end
    rand_sweep(0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
